ula_serial_adder: RTL and testbench
===================================

// Module: ula_serial_adder
// PURPOSE
//   Bit-serial WIDTH-bit adder for the ULA datapath. Latches two operands on a
//   start pulse and adds them one bit per clock, LSB first. Each bit is a full
//   add built from two half-adder stages (s/c), with an OR merging the two carries.
//   The running carry is held in a flip-flop. Presents a registered sum, carry-out
//   and signed overflow with a one-cycle done pulse, for the ULA result/flag logic.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (>= 2)
// PORTS
//   clk    in   1      rising-edge clock, single clock domain
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      request; sampled only in IDLE
//   a      in   WIDTH  operand A, sampled on the accepting edge
//   b      in   WIDTH  operand B, sampled on the accepting edge
//   cin    in   1      carry-in, sampled on the accepting edge
//   busy   out  1      high while in RUN
//   done   out  1      one-cycle pulse: s/cout/ovf just updated
//   s      out  WIDTH  registered sum, held until the next result
//   cout   out  1      registered carry out of the MSB
//   ovf    out  1      registered signed overflow (carry into MSB XOR cout)
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE; busy, done, s, cout and ovf = 0.
//     Bit counter, operand shift registers and carry FF are also cleared.
//   States: IDLE, RUN, DONE (registered FSM). All outputs are registered.
//   IDLE:
//     If start=1 at edge E0: latch a and b into shift registers, carry FF <= cin,
//     cnt <= 0, go to RUN, busy <= 1.
//     If start=0: stay in IDLE; outputs hold their values.
//   RUN, edges E1..E(WIDTH), one bit per edge:
//     sum_i = a_i ^ b_i ^ c.
//     c <= (a_i & b_i) | ((a_i ^ b_i) & c).
//     sum_i shifts into the internal result register from the MSB side.
//     Operand registers shift right; cnt increments.
//     At bit WIDTH-1, record the carry into the MSB for overflow.
//     At edge E(WIDTH): s <= full result, cout <= final carry,
//     ovf <= c_into_msb ^ cout, done <= 1, busy <= 0, go to DONE.
//   DONE: for one cycle only. At the next edge: done <= 0, go to IDLE.
//   Latency: done goes high exactly WIDTH edges after the accepting edge E0.
//     Next accept is possible no earlier than WIDTH+2 edges after E0.
//   start in RUN or DONE is ignored; the operands in flight are not disturbed.
//     start held high continuously restarts on the first IDLE edge.
//   a, b and cin may change freely after E0 without effect.
//   s, cout and ovf keep the previous result throughout RUN. No partial sums are visible.
//   rst mid-RUN or in DONE: operation is abandoned, no done pulse, all outputs 0.
//   Sum is modulo 2^WIDTH. The carry FF is the only inter-bit state.
// TESTING (WIDTH=8)
//   1. a=0x0F b=0x01 cin=0 -> s=0x10 cout=0 ovf=0; done high 8 edges after accept, for exactly 1 cycle.
//   2. a=0xFF b=0x01 cin=0 -> s=0x00 cout=1 ovf=0 (unsigned wrap).
//   3. a=0x7F b=0x01 cin=0 -> s=0x80 cout=0 ovf=1; then a=0x80 b=0x80 cin=1 -> s=0x01 cout=1 ovf=1.
//   4. Accept a=0x12 b=0x34, then pulse start with a=0xFF b=0xFF during RUN and DONE.
//      -> single result s=0x46; busy never drops early.
//   5. Pulse rst at the 4th RUN edge -> busy, done, s, cout, ovf = 0 immediately, no done pulse.
//      Then a=0x03 b=0x05 -> s=0x08.
//   6. Back-to-back: start held high -> results every 10 cycles.
//      s holds the old value until each done; random a/b/cin checked against (a+b+cin).

Source files
------------

// File: rtl/ula_serial_adder.sv
// ula_serial_adder: bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// A start pulse in idle latches both operands and the carry-in. WIDTH edges later the
// registered sum, carry-out and signed overflow update together with a one-cycle done pulse.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   request, sampled only in idle
//   a, b   in   WIDTH-bit operands, sampled on the accepting edge
//   cin    in   carry-in, sampled on the accepting edge
//   busy   out  high while bits are being added
//   done   out  one-cycle pulse when s/cout/ovf have just updated
//   s      out  registered sum, held until the next result
//   cout   out  registered carry out of the MSB
//   ovf    out  registered signed overflow
module ula_serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_opa, w_opa_nxt;
  logic [WIDTH-1:0] r_opb, w_opb_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic [CntW-1:0]  r_cnt, w_cnt_nxt;
  logic             r_c, w_c_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [WIDTH-1:0] r_s, w_s_nxt;
  logic             r_cout, w_cout_nxt;
  logic             r_ovf, w_ovf_nxt;

  // Full adder from two half-adder stages; the OR merges the two stage carries.
  logic w_hs1, w_hc1, w_sum, w_hc2, w_carry;
  assign w_hs1   = r_opa[0] ^ r_opb[0];
  assign w_hc1   = r_opa[0] & r_opb[0];
  assign w_sum   = w_hs1 ^ r_c;
  assign w_hc2   = w_hs1 & r_c;
  assign w_carry = w_hc1 | w_hc2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_opa   <= '0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_opa   <= w_opa_nxt;
      r_opb   <= w_opb_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_c     <= w_c_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_s     <= w_s_nxt;
      r_cout  <= w_cout_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_opa_nxt   = r_opa;
    w_opb_nxt   = r_opb;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_c_nxt     = r_c;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_s_nxt     = r_s;
    w_cout_nxt  = r_cout;
    w_ovf_nxt   = r_ovf;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_opa_nxt   = a;
          w_opb_nxt   = b;
          w_c_nxt     = cin;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        w_opa_nxt = {1'b0, r_opa[WIDTH-1:1]};
        w_opb_nxt = {1'b0, r_opb[WIDTH-1:1]};
        w_c_nxt   = w_carry;
        // Sum bits enter at the MSB, so after WIDTH shifts bit 0 holds the first sum bit.
        w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
        w_cnt_nxt = r_cnt + CntW'(1);
        if (r_cnt == LastCnt) begin
          // On the last bit r_c is the carry into the MSB.
          w_s_nxt     = {w_sum, r_acc[WIDTH-1:1]};
          w_cout_nxt  = w_carry;
          w_ovf_nxt   = r_c ^ w_carry;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        w_done_nxt  = 1'b0;
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign busy = r_busy;
  assign done = r_done;
  assign s    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_ula_serial_adder.sv
// tb_ula_serial_adder: directed, table-driven bench for ula_serial_adder (WIDTH=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ula_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done;
  logic [7:0] s;
  logic       cout, ovf;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[8];

  ula_serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete operation: accept, scramble the inputs, wait for done, check the result.
  task automatic run_op(input vec_t v, input string tag);
    int         lat;
    logic       seen;
    logic [7:0] old_s;
    old_s = s;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~v.a; b = 8'h5A; cin = ~v.cin;
    chk({tag, " busy after accept"}, busy, 1);
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat  = k;
      end else begin
        chk({tag, " s held during run"}, s, old_s);
      end
    end
    chk({tag, " done latency"}, lat, 8);
    chk({tag, " s"}, s, v.s);
    chk({tag, " cout"}, cout, v.cout);
    chk({tag, " ovf"}, ovf, v.ovf);
    chk({tag, " busy at done"}, busy, 0);
    @(negedge clk);
    chk({tag, " done one cycle"}, done, 0);
  endtask

  initial begin
    int         ndone;
    int         cyc;
    int         got;
    int         last_cyc;
    logic [7:0] ra, rb, old_s;
    logic       rc;
    logic [8:0] tot;

    vecs[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, s: 8'h10, cout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, s: 8'h80, cout: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, s: 8'h01, cout: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 8'hAA, b: 8'h55, cin: 1'b1, s: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[5] = '{a: 8'h40, b: 8'h40, cin: 1'b0, s: 8'h80, cout: 1'b0, ovf: 1'b1};
    vecs[6] = '{a: 8'hC0, b: 8'hC0, cin: 1'b0, s: 8'h80, cout: 1'b1, ovf: 1'b0};
    vecs[7] = '{a: 8'h80, b: 8'h80, cin: 1'b1, s: 8'h01, cout: 1'b1, ovf: 1'b1};

    // Reset state
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset s", s, 0);
    chk("reset cout", cout, 0);
    chk("reset ovf", ovf, 0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // start pulses during RUN and DONE are ignored
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'hFF; b = 8'hFF;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("ignore busy in run", busy, 1);
      chk("ignore no early done", done, 0);
      start = (k % 2 == 1);
    end
    @(negedge clk);
    chk("ignore done", done, 1);
    chk("ignore s", s, 8'h46);
    chk("ignore cout", cout, 0);
    chk("ignore ovf", ovf, 0);
    @(negedge clk);
    start = 1'b0;
    chk("ignore done drops", done, 0);
    chk("ignore idle busy", busy, 0);
    @(negedge clk);
    chk("ignore no restart", busy, 0);

    // Async reset at the 4th RUN edge
    @(negedge clk);
    a = 8'h55; b = 8'h22; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort s", s, 0);
    chk("abort cout", cout, 0);
    chk("abort ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort no done pulse", ndone, 0);
    run_op('{a: 8'h03, b: 8'h05, cin: 1'b0, s: 8'h08, cout: 1'b0, ovf: 1'b0}, "post-abort");

    // Back-to-back with start held high
    old_s = s;
    @(negedge clk);
    ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
    a = ra; b = rb; cin = rc; start = 1'b1;
    cyc = 0; got = 0; last_cyc = 0;
    while (got < 4 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        tot = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
        chk("b2b s", s, tot[7:0]);
        chk("b2b cout", cout, tot[8]);
        chk("b2b ovf", ovf, (ra[7] == rb[7]) && (tot[7] != ra[7]));
        if (got > 0) chk("b2b interval", cyc - last_cyc, 10);
        last_cyc = cyc;
        got++;
        old_s = s;
        ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
        a = ra; b = rb; cin = rc;
      end else begin
        chk("b2b s held", s, old_s);
      end
    end
    chk("b2b result count", got, 4);
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
